// File: rtl/bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_sequencer
// Function : Moore control-step sequencer driving the single-bus datapath.
// Revision : 1.0
// ============================================================================
module bus_sequencer #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    output logic [23:0] bus_drv,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        reg_in,
    output logic        mdr_from_mem,
    output logic        inc_pc,
    output logic [3:0]  reg_dst,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic        fault
);

    localparam logic [4:0] SRC_HI  = 5'd16;
    localparam logic [4:0] SRC_LO  = 5'd17;
    localparam logic [4:0] SRC_ZLO = 5'd19;
    localparam logic [4:0] SRC_PC  = 5'd20;
    localparam logic [4:0] SRC_MDR = 5'd21;
    localparam logic [4:0] SRC_C   = 5'd23;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_FWAIT, S_T2, S_T3, S_T4,
        S_T5, S_T6, S_MWAIT, S_T7, S_HALT, S_FAULT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [16:0] ir_q;
    logic [16:0] fields;
    logic [7:0]  wait_cnt;
    logic [4:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        is_rtype;
    logic        is_addi;
    logic        is_ld;
    logic        is_st;
    logic        wait_expired;
    logic        unused_ir_low;

    // The IR register loads at the T2 edge, so T3 decodes the live ir and later steps use the copy.
    assign fields        = (state == S_T3) ? ir[31:15] : ir_q;
    assign op            = fields[16:12];
    assign ra            = fields[11:8];
    assign rb            = fields[7:4];
    assign rc            = fields[3:0];
    assign unused_ir_low = ^ir[14:0];

    assign is_rtype     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_addi      = (op == OP_ADDI);
    assign is_ld        = (op == OP_LD);
    assign is_st        = (op == OP_ST);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= S_IDLE;
            ir_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_T3) begin
                ir_q <= ir[31:15];
            end
            if ((state == S_FWAIT) || (state == S_MWAIT)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state   = state;
        bus_drv      = '0;
        pc_in        = 1'b0;
        ir_in        = 1'b0;
        mar_in       = 1'b0;
        mdr_in       = 1'b0;
        y_in         = 1'b0;
        z_in         = 1'b0;
        reg_in       = 1'b0;
        mdr_from_mem = 1'b0;
        inc_pc       = 1'b0;
        reg_dst      = 4'd0;
        alu_op       = 4'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) next_state = S_T0;
            end
            S_T0: begin
                bus_drv[SRC_PC] = 1'b1;
                mar_in          = 1'b1;
                inc_pc          = 1'b1;
                z_in            = 1'b1;
                next_state      = S_T1;
            end
            S_T1: begin
                bus_drv[SRC_ZLO] = 1'b1;
                pc_in            = 1'b1;
                next_state       = S_FWAIT;
            end
            S_FWAIT: begin
                mem_read     = 1'b1;
                mdr_from_mem = 1'b1;
                if (mem_ack) begin
                    mdr_in     = 1'b1;
                    next_state = S_T2;
                end else if (wait_expired) begin
                    next_state = S_FAULT;
                end
            end
            S_T2: begin
                bus_drv[SRC_MDR] = 1'b1;
                ir_in            = 1'b1;
                next_state       = S_T3;
            end
            S_T3: begin
                if (is_rtype || is_addi || is_ld || is_st) begin
                    bus_drv[{1'b0, rb}] = 1'b1;
                    y_in                = 1'b1;
                    next_state          = S_T4;
                end else if (op == OP_MFHI) begin
                    bus_drv[SRC_HI] = 1'b1;
                    reg_in          = 1'b1;
                    reg_dst         = ra;
                    next_state      = S_T0;
                end else if (op == OP_MFLO) begin
                    bus_drv[SRC_LO] = 1'b1;
                    reg_in          = 1'b1;
                    reg_dst         = ra;
                    next_state      = S_T0;
                end else if (op == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    fault      = 1'b1;
                    next_state = S_T0;
                end
            end
            S_T4: begin
                z_in       = 1'b1;
                next_state = S_T5;
                if (is_rtype) begin
                    bus_drv[{1'b0, rc}] = 1'b1;
                    case (op)
                        OP_SUB:  alu_op = 4'd1;
                        OP_AND:  alu_op = 4'd2;
                        OP_OR:   alu_op = 4'd3;
                        default: alu_op = 4'd0;
                    endcase
                end else begin
                    bus_drv[SRC_C] = 1'b1;
                end
            end
            S_T5: begin
                bus_drv[SRC_ZLO] = 1'b1;
                if (is_ld || is_st) begin
                    mar_in     = 1'b1;
                    next_state = is_ld ? S_MWAIT : S_T6;
                end else begin
                    reg_in     = 1'b1;
                    reg_dst    = ra;
                    next_state = S_T0;
                end
            end
            S_T6: begin
                bus_drv[{1'b0, ra}] = 1'b1;
                mdr_in              = 1'b1;
                next_state          = S_MWAIT;
            end
            S_MWAIT: begin
                if (is_ld) begin
                    mem_read     = 1'b1;
                    mdr_from_mem = 1'b1;
                    mdr_in       = mem_ack;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ack) begin
                    next_state = is_ld ? S_T7 : S_T0;
                end else if (wait_expired) begin
                    next_state = S_FAULT;
                end
            end
            S_T7: begin
                bus_drv[SRC_MDR] = 1'b1;
                reg_in           = 1'b1;
                reg_dst          = ra;
                next_state       = S_T0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`default_nettype none
// tb_bus_sequencer : randomized instruction stream checked cycle by cycle against
// a per-instruction control-step model built from the instruction's timing rules.
module tb_bus_sequencer;

    localparam int WAIT_MAX = 255;

    localparam int F_PC  = 1 << 0;
    localparam int F_IR  = 1 << 1;
    localparam int F_MAR = 1 << 2;
    localparam int F_MDR = 1 << 3;
    localparam int F_Y   = 1 << 4;
    localparam int F_Z   = 1 << 5;
    localparam int F_REG = 1 << 6;
    localparam int F_INC = 1 << 7;
    localparam int F_RD  = 1 << 8;
    localparam int F_WR  = 1 << 9;
    localparam int F_HLT = 1 << 10;
    localparam int F_FLT = 1 << 11;

    localparam int B_NONE = -1;
    localparam int B_HI   = 16;
    localparam int B_LO   = 17;
    localparam int B_ZLO  = 19;
    localparam int B_PC   = 20;
    localparam int B_MDR  = 21;
    localparam int B_C    = 23;

    localparam int ACK_ANY = 2;

    typedef struct {
        int src;
        int flags;
        int dst;
        int alu;
        int ack;
        bit irv;
        bit fm;
    } rec_t;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        run;
    logic [31:0] ir;
    logic        mem_ack;
    logic [23:0] bus_drv;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, reg_in;
    logic        mdr_from_mem, inc_pc;
    logic [3:0]  reg_dst, alu_op;
    logic        mem_read, mem_write, halted, fault;
    logic [11:0] flags_obs;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

    bus_sequencer #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clock(clock), .clear_n(clear_n), .run(run), .ir(ir), .mem_ack(mem_ack),
        .bus_drv(bus_drv), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .reg_in(reg_in),
        .mdr_from_mem(mdr_from_mem), .inc_pc(inc_pc), .reg_dst(reg_dst),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .halted(halted), .fault(fault)
    );

    assign flags_obs = {fault, halted, mem_write, mem_read, inc_pc, reg_in,
                        z_in, y_in, mdr_in, mar_in, ir_in, pc_in};

    always #5 clock = ~clock;

    task automatic push(input int src, input int flags, input int dst, input int alu,
                        input int ack, input bit irv, input bit fm);
        rec_t r;
        r.src = src; r.flags = flags; r.dst = dst; r.alu = alu;
        r.ack = ack; r.irv = irv; r.fm = fm;
        q.push_back(r);
    endtask

    // Expected control word of every cycle of one instruction, derived from its class.
    task automatic build(input logic [31:0] ins, input int df, input int dm, input bit timeout);
        int op, ra, rb, rc, req;
        bit is_r, is_ai, is_ld, is_st;
        op = int'(ins[31:27]); ra = int'(ins[26:23]); rb = int'(ins[22:19]); rc = int'(ins[18:15]);
        is_r  = (op >= 3) && (op <= 6);
        is_ai = (op == 12);
        is_ld = (op == 0);
        is_st = (op == 2);
        q.delete();
        push(B_PC, F_MAR | F_INC | F_Z, 0, 0, ACK_ANY, 0, 0);
        push(B_ZLO, F_PC, 0, 0, ACK_ANY, 0, 0);
        repeat (df) push(B_NONE, F_RD, 0, 0, 0, 0, 0);
        push(B_NONE, F_RD | F_MDR, 0, 0, 1, 0, 1);
        push(B_MDR, F_IR, 0, 0, ACK_ANY, 0, 0);
        if (is_r || is_ai || is_ld || is_st) begin
            push(rb, F_Y, 0, 0, ACK_ANY, 1, 0);
            push(is_r ? rc : B_C, F_Z, 0, is_r ? op - 3 : 0, ACK_ANY, 1, 0);
            if (is_r || is_ai) begin
                push(B_ZLO, F_REG, ra, 0, ACK_ANY, 1, 0);
            end else begin
                push(B_ZLO, F_MAR, 0, 0, ACK_ANY, 1, 0);
                if (is_st) push(ra, F_MDR, 0, 0, ACK_ANY, 1, 0);
                req = is_ld ? F_RD : F_WR;
                if (timeout) begin
                    repeat (WAIT_MAX) push(B_NONE, req, 0, 0, 0, 1, 0);
                    repeat (4) push(B_NONE, F_HLT | F_FLT, 0, 0, ACK_ANY, 1, 0);
                end else begin
                    repeat (dm) push(B_NONE, req, 0, 0, 0, 1, 0);
                    push(B_NONE, is_ld ? (F_RD | F_MDR) : F_WR, 0, 0, 1, 1, is_ld);
                    if (is_ld) push(B_MDR, F_REG, ra, 0, ACK_ANY, 1, 0);
                end
            end
        end else if (op == 24) begin
            push(B_HI, F_REG, ra, 0, ACK_ANY, 1, 0);
        end else if (op == 25) begin
            push(B_LO, F_REG, ra, 0, ACK_ANY, 1, 0);
        end else if (op == 27) begin
            push(B_NONE, 0, 0, 0, ACK_ANY, 1, 0);
            repeat (5) push(B_NONE, F_HLT, 0, 0, ACK_ANY, 1, 0);
        end else begin
            push(B_NONE, F_FLT, 0, 0, ACK_ANY, 1, 0);
        end
    endtask

    task automatic check_cycle(input rec_t r, input string tag);
        logic [23:0] eb;
        logic [11:0] ef;
        eb = (r.src >= 0) ? (24'd1 << r.src) : 24'd0;
        ef = 12'(r.flags);
        total++;
        assert (bus_drv === eb) else begin
            bad++; $error("FAIL %s bus_drv got=%h exp=%h", tag, bus_drv, eb);
        end
        total++;
        assert (flags_obs === ef) else begin
            bad++; $error("FAIL %s strobes got=%h exp=%h", tag, flags_obs, ef);
        end
        total++;
        assert (($countones(bus_drv) <= 1) && !(mem_read && mem_write)) else begin
            bad++; $error("FAIL %s invariant bus=%h rd=%b wr=%b exp=onehot/excl", tag, bus_drv, mem_read, mem_write);
        end
        if (ef[3]) begin
            total++;
            assert (mdr_from_mem === r.fm) else begin
                bad++; $error("FAIL %s mdr_from_mem got=%b exp=%b", tag, mdr_from_mem, r.fm);
            end
        end
        if (ef[6]) begin
            total++;
            assert (reg_dst === 4'(r.dst)) else begin
                bad++; $error("FAIL %s reg_dst got=%0d exp=%0d", tag, reg_dst, r.dst);
            end
        end
        if (ef[5] && !ef[7]) begin
            total++;
            assert (alu_op === 4'(r.alu)) else begin
                bad++; $error("FAIL %s alu_op got=%0d exp=%0d", tag, alu_op, r.alu);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert ({bus_drv, flags_obs, mdr_from_mem, reg_dst, alu_op} === 45'd0) else begin
            bad++; $error("FAIL %s outputs got=%h exp=0", tag,
                          {bus_drv, flags_obs, mdr_from_mem, reg_dst, alu_op});
        end
    endtask

    task automatic exec(input logic [31:0] ins, input int df, input int dm,
                        input bit timeout, input int limit, input string name);
        int n;
        build(ins, df, dm, timeout);
        n = ((limit > 0) && (limit < q.size())) ? limit : q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            ir      = q[i].irv ? ins : $urandom();
            mem_ack = (q[i].ack == ACK_ANY) ? 1'($urandom_range(0, 1)) : 1'(q[i].ack);
            run     = 1'($urandom_range(0, 1));
            #1;
            check_cycle(q[i], $sformatf("%s[%0d]", name, i));
        end
    endtask

    task automatic release_and_idle(input string name);
        run = 1'b0;
        @(posedge clock);
        #3 clear_n = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #2;
            check_zero(name);
        end
        run = 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] rnd;
        int          op;
        int          kind;

        clear_n = 1'b0; run = 1'b0; mem_ack = 1'b0; ir = '0;
        #12;
        check_zero("reset");
        release_and_idle("idle_hold");

        exec(32'h1891_8000, 0, 0, 0, 0, "add");
        exec({5'd0, 4'd4, 4'd5, 4'd0, 15'h0010}, 0, 3, 0, 0, "ld");
        exec({5'd2, 4'd6, 4'd7, 4'd0, 15'h0000}, $urandom_range(0, 2), 2, 0, 0, "st");
        exec({5'd31, 27'h123_4567}, 0, 0, 0, 0, "illegal");

        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 8);
            case (kind)
                0, 1, 2, 3: op = 3 + kind;
                4:          op = 12;
                5:          op = 0;
                6:          op = 2;
                7:          op = 24 + $urandom_range(0, 1);
                default: begin
                    do op = $urandom_range(0, 31);
                    while (op inside {0, 2, 3, 4, 5, 6, 12, 24, 25, 27});
                end
            endcase
            rnd = $urandom();
            ins = {5'(op), rnd[26:0]};
            exec(ins, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, $sformatf("rand%0d", k));
        end

        exec({5'd24, 4'd9, 23'd0}, 1, 0, 0, 0, "mfhi");
        exec({5'd27, 27'd0}, 0, 0, 0, 0, "halt");
        #1 clear_n = 1'b0;
        #1 check_zero("clear_halt");
        release_and_idle("idle_after_halt");

        exec({5'd2, 4'd3, 4'd8, 4'd0, 15'h0004}, 0, 10, 0, 10, "st_abort");
        #1 clear_n = 1'b0;
        #1 check_zero("abort_async");
        mem_ack = 1'b1;
        #1 check_zero("abort_ack_ignored");
        mem_ack = 1'b0;
        release_and_idle("idle_after_abort");

        exec(32'h1891_8000, 2, 0, 0, 0, "recover");
        exec({5'd2, 4'd1, 4'd2, 19'd0}, 0, 0, 1, 0, "timeout");
        #1 clear_n = 1'b0;
        #1 check_zero("clear_fault");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_sequencer.md
# bus_sequencer

Control-step sequencer for the single-bus datapath. A Moore FSM steps through fetch and execute control steps for each instruction. Every cycle it drives a one-hot bus-source vector straight into the bus multiplexer's 24 source-enable inputs, plus the register load strobes, the ALU opcode and a req/ack memory handshake. It sits between the instruction register and the datapath, and is the only block that selects the bus source.

## Interface
Parameters:
- MEM_WAIT_MAX, 255, cycles without mem_ack before the sequencer aborts to FAULT.

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous, active-low reset
- run  in  1  start/continue; sampled in IDLE
- ir  in  32  instruction register contents: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- mem_ack  in  1  memory completion, single-cycle pulse
- bus_drv  out  24  one-hot bus source, bit order: R0..R15 (0-15), HI 16, LO 17, ZHI 18, ZLO 19, PC 20, MDR 21, InPort 22, C 23; all-zero means the bus reads 0
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, reg_in  out  1 each  load strobes
- mdr_from_mem  out  1  MDR source select: 1 = memory data, 0 = bus
- inc_pc  out  1  ALU computes bus+1
- reg_dst  out  4  register-file write index, valid with reg_in
- alu_op  out  4  0 add, 1 sub, 2 and, 3 or; valid with z_in
- mem_read, mem_write  out  1 each  memory request, held until ack
- halted, fault  out  1 each  status flags

## Operation
- All outputs are decoded from the state register and the latched ir only. No output depends combinationally on mem_ack, except mdr_in in the read-wait states.
- Reset value: every output is 0, and the state is IDLE.
- States: IDLE, T0, T1, FWAIT, T2, T3, T4, T5, T6, MWAIT, T7, HALT, FAULT.
- IDLE: outputs idle. Go to T0 when run=1.
- T0: bus_drv[PC], mar_in, inc_pc, z_in.
- T1: bus_drv[ZLO], pc_in.
- FWAIT: mem_read=1. When mem_ack=1, assert mdr_in with mdr_from_mem=1 and go to T2.
- T2: bus_drv[MDR], ir_in.
- T3, by op:
  - R-type (00011 add, 00100 sub, 00101 and, 00110 or), addi (01100), ld (00000), st (00010): bus_drv[rb], y_in.
  - mfhi (11000): bus_drv[HI], reg_in, reg_dst=ra, then T0.
  - mflo (11001): bus_drv[LO], reg_in, reg_dst=ra, then T0.
  - halt (11011): go to HALT.
  - Any other op: assert fault for 1 cycle, then T0 (instruction skipped).
- T4:
  - R-type: bus_drv[rc], alu_op from op, z_in.
  - addi, ld, st: bus_drv[C], alu_op=add, z_in.
- T5:
  - R-type, addi: bus_drv[ZLO], reg_in, reg_dst=ra, then T0.
  - ld, st: bus_drv[ZLO], mar_in.
- T6:
  - ld: go directly to MWAIT with mem_read.
  - st: bus_drv[ra], mdr_in, mdr_from_mem=0, then MWAIT with mem_write.
- MWAIT: hold the request.
  - ld: on ack, mdr_in with mdr_from_mem=1, then T7.
  - st: on ack, go to T0.
- T7 (ld only): bus_drv[MDR], reg_in, reg_dst=ra, then T0.
- HALT: halted=1, outputs otherwise idle. Left only via clear_n.
- FAULT: fault=1 and halted=1. Entered when a wait counter (8-bit, cleared on entering FWAIT/MWAIT) reaches MWAIT_MAX. Left only via clear_n.
- Invariant: popcount(bus_drv) ≤ 1 in every cycle. mem_read and mem_write are never both 1.

## Timing
- Register ops (R-type, addi), best case: T0,T1,FWAIT,T2,T3,T4,T5 = 7 cycles, with mem_ack arriving in FWAIT's first cycle.
- mfhi/mflo: 5 cycles. ld: 9 cycles minimum. st: 9 cycles minimum.
- Each cycle of ack delay adds exactly 1 cycle.
- mem_ack outside FWAIT/MWAIT is ignored.
- ir is sampled by downstream logic at the T2 edge. The decode from T3 onward uses ir from the cycle after T2.
- clear_n low at any point, including mid-handshake: all outputs drop to 0 asynchronously, the request is withdrawn, and the state goes to IDLE. After release, the first transition occurs on the next rising clock edge with run=1.
- run is ignored outside IDLE.

## Test plan
- Reset then run=1, ack on the first FWAIT cycle, ir=add R1,R2,R3 (0x18918000). Expected bus_drv sequence: PC, ZLO, 0, MDR, R2, R3, ZLO. reg_in with reg_dst=1 at cycle 7, then back to T0.
- ld R4,0x10(R5): bus_drv C at T4, mar_in at T5. Delay ack 3 cycles: mem_read stays high for 4 cycles, then T7 drives bus_drv[MDR] with reg_dst=4. Total 12 cycles.
- st R6,0(R7): bus_drv[R6] with mdr_in and mdr_from_mem=0 at T6. mem_write is held until ack, and mem_read=0 throughout.
- mfhi R9, then halt: bus_drv[HI] with reg_dst=9. halted=1 after halt, with no further mem_read despite mem_ack pulses. clear_n returns to IDLE.
- Illegal op 11111: fault pulses for 1 cycle and the next fetch begins. With mem_ack never asserted for MWAIT_MAX cycles: fault=1 and halted=1 persist.
- clear_n asserted in MWAIT with mem_write=1: all outputs are 0 before the next clock edge. Across all scenarios, a checker asserts popcount(bus_drv) ≤ 1 every cycle.
